rv32i_fetch_decode_execute: RTL and testbench
=============================================

Name: rv32i_fetch_decode_execute

Overview:
Single-cycle RV32I front end combining three functions: instruction fetch (PC register), decode (control plus 32x32 register file), and execute (ALU, branch resolution). Instruction memory is external and combinational. Data memory and the load/ALU writeback mux are external; the selected writeback value returns on wb_value and is written to the register file at the next clock edge. One instruction completes per clock.

Parameters:
XLEN, 32, datapath/register/PC width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
imem_addr  out  XLEN  current PC, byte address.
imem_rdata  in  32  instruction at imem_addr, combinational.
wb_value  in  XLEN  writeback data for rd (ALU result or load data, muxed externally).
pc_out  out  XLEN  PC of the current instruction (equal to imem_addr).
alu_result  out  XLEN  execute result or memory address.
alu_zero  out  1  alu_result == 0.
store_data  out  XLEN  rs2 value.
mem_read  out  1  current instruction is a LOAD.
mem_write  out  1  current instruction is a STORE.
wb_from_load  out  1  writeback source select: 1 means load data.
funct3_out  out  3  instr[14:12], passed through as memory size/sign.
rd_out  out  5  destination register, instr[11:7].
reg_write  out  1  instruction writes rd.
branch_taken  out  1  next PC is branch_target.
branch_target  out  XLEN  redirect address.

Behaviour:
- Reset (rst=0, asynchronous, including mid-run): PC=RESET_PC; x1..x31=0. Outputs are combinational from PC, imem_rdata and the register file.
- Each rising edge with rst=1: PC <= branch_taken ? branch_target : PC+4, modulo 2^XLEN. If reg_write and rd!=0, regfile[rd] <= wb_value.
- Register file: two combinational read ports. x0 always reads 0, and writes to x0 are discarded. No bypass: the write lands at the edge and the next instruction reads the new value.
- Immediates follow RV32I I/S/B/U/J formats, sign-extended to XLEN.
- LUI: result=imm, reg_write=1.
- AUIPC: result=PC+imm, reg_write=1.
- JAL: result=PC+4, target=PC+imm, taken=1, reg_write=1.
- JALR: result=PC+4, target=(rs1+imm)&~1, taken=1, reg_write=1.
- BRANCH: result=rs1-rs2, target=PC+imm, reg_write=0. taken by funct3: BEQ 000, BNE 001, BLT 100, BGE 101 (signed), BLTU 110, BGEU 111 (unsigned). funct3 010/011 gives taken=0.
- LOAD: result=rs1+imm_I; mem_read=1, wb_from_load=1, reg_write=1.
- STORE: result=rs1+imm_S; mem_write=1, reg_write=0.
- OP-IMM / OP ALU operations: ADD, SUB (OP only, funct7[5]=1), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]=1, both formats), OR, AND. Shift amount is the low 5 bits. SLT/SLTU results are 0/1.
- Unknown opcodes, FENCE and SYSTEM execute as NOP: no register write, no memory access, not taken, PC+4.
- wb_from_load=0 and mem_read=mem_write=0 for all non-memory instructions.
- Misaligned targets raise no exception; the PC takes the value as computed.

Decomposition:
- Shared package: opcode constants, funct3/funct7 constants, ALU operation enum, immediate-format enum.
- One sub-module, rv32i_regfile: 32xXLEN, 2 read ports, 1 write port, asynchronous active-low clear. The ALU and decoder stay inline.

Test Plan:
1. Reset and NOP stream: hold rst=0, check imem_addr=0. Release and feed 0x00000013 every cycle: imem_addr steps 0, 4, 8, with reg_write to x0 having no effect. Assert rst mid-run: imem_addr=0 immediately.
2. ALU write path: at PC=0, ADDI x1,x0,5 (0x00500093) gives alu_result=5, rd_out=1, reg_write=1; drive wb_value=5. Next, ADD x2,x1,x1 (0x00108133) gives alu_result=10. SUB x3,x1,x2 (0x402081B3) gives 0xFFFFFFFB.
3. Shifts and compares with x1=0xFFFFFFF8: SRAI x4,x1,1 gives 0xFFFFFFFC; SRLI x4,x1,1 gives 0x7FFFFFFC; SLTU x5,x0,x1 gives 1; SLT x5,x1,x0 gives 1.
4. Branches at PC=0x10 with x1==x1: BEQ x1,x1,+8 gives taken=1, target=0x18, next imem_addr=0x18. BNE x1,x1,+8 gives taken=0, next 0x14.
5. Jumps: JAL x1,+16 at PC=0x20 gives alu_result=0x24, next PC 0x30. JALR x0,0(x5) with x5=0x101 gives target=0x100; x0 stays 0.
6. Memory: with x2=0x100 and x3=0xAB, SW x3,4(x2) gives mem_write=1, alu_result=0x104, store_data=0xAB, funct3_out=010, reg_write=0. LW x6,4(x2) gives mem_read=1, wb_from_load=1; drive wb_value=0xAB, then x6 reads 0xAB.

Source files
------------

// File: rtl/rv32i_fetch_decode_execute_pkg.sv
// Shared encodings for the RV32I single-cycle front end: opcodes, funct fields,
// ALU operation and immediate-format enums, plus the funct3/funct7 to ALU-op map.
package rv32i_fetch_decode_execute_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct7[5] lives at instruction bit 30; it selects SUB and SRA/SRAI
   localparam int F7_ALT_BIT = 30;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_e;

   // SUB only exists in the register form; ADDI ignores bit 30 of its immediate
   function automatic alu_op_e decode_alu_op(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       allow_sub);
      alu_op_e op;
      case (funct3)
         F3_ADD_SUB: op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_fetch_decode_execute_regfile.sv
// 32-entry register file: two combinational read ports, one write port,
// x0 hard-wired to zero, asynchronous active-low clear.
module rv32i_regfile
   import rv32i_fetch_decode_execute_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata
);

   logic [XLEN-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv32i_fetch_decode_execute.sv
// Single-cycle RV32I fetch/decode/execute: PC register, decoder, register file,
// ALU and branch resolution. Memory and the writeback mux sit outside.
module rv32i_fetch_decode_execute
   import rv32i_fetch_decode_execute_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic [XLEN-1:0] wb_value,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] alu_result,
   output logic            alu_zero,
   output logic [XLEN-1:0] store_data,
   output logic            mem_read,
   output logic            mem_write,
   output logic            wb_from_load,
   output logic [2:0]      funct3_out,
   output logic [4:0]      rd_out,
   output logic            reg_write,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] target_base;
   logic [31:0]     imm32;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            alt;
   logic            br_cond;
   logic            link;
   logic [4:0]      shamt;
   imm_fmt_e        imm_fmt;
   alu_op_e         alu_op;

   assign opcode   = imem_rdata[6:0];
   assign funct3   = imem_rdata[14:12];
   assign alt      = imem_rdata[F7_ALT_BIT];
   assign pc_plus4 = pc + XLEN'(4);

   assign imem_addr  = pc;
   assign pc_out     = pc;
   assign store_data = rs2_val;
   assign funct3_out = funct3;
   assign rd_out     = imem_rdata[11:7];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= branch_taken ? branch_target : pc_plus4;
      end
   end

   rv32i_regfile #(.XLEN(XLEN)) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (imem_rdata[19:15]),
      .raddr2 (imem_rdata[24:20]),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val),
      .we     (reg_write),
      .waddr  (rd_out),
      .wdata  (wb_value)
   );

   always_comb begin
      case (opcode)
         OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
         OPC_JAL:            imm_fmt = IMM_J;
         OPC_BRANCH:         imm_fmt = IMM_B;
         OPC_STORE:          imm_fmt = IMM_S;
         default:            imm_fmt = IMM_I;
      endcase
   end

   always_comb begin
      case (imm_fmt)
         IMM_S:   imm32 = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
         IMM_B:   imm32 = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                           imem_rdata[30:25], imem_rdata[11:8], 1'b0};
         IMM_U:   imm32 = {imem_rdata[31:12], 12'b0};
         IMM_J:   imm32 = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                           imem_rdata[20], imem_rdata[30:21], 1'b0};
         default: imm32 = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      endcase
      imm = XLEN'($signed(imm32));
   end

   always_comb begin
      case (funct3)
         F3_BEQ:  br_cond = (rs1_val == rs2_val);
         F3_BNE:  br_cond = (rs1_val != rs2_val);
         F3_BLT:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
         F3_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
         F3_BLTU: br_cond = (rs1_val <  rs2_val);
         F3_BGEU: br_cond = (rs1_val >= rs2_val);
         default: br_cond = 1'b0;
      endcase
   end

   // Control decode; anything not listed (FENCE, SYSTEM, unknown) falls through as a NOP
   always_comb begin
      operand_a    = rs1_val;
      operand_b    = imm;
      alu_op       = ALU_ADD;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      wb_from_load = 1'b0;
      branch_taken = 1'b0;
      link         = 1'b0;
      case (opcode)
         OPC_LUI: begin
            operand_a = '0;
            reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            operand_a = pc;
            reg_write = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            link         = 1'b1;
            branch_taken = 1'b1;
            reg_write    = 1'b1;
         end
         OPC_BRANCH: begin
            operand_b    = rs2_val;
            alu_op       = ALU_SUB;
            branch_taken = br_cond;
         end
         OPC_LOAD: begin
            mem_read     = 1'b1;
            wb_from_load = 1'b1;
            reg_write    = 1'b1;
         end
         OPC_STORE: begin
            mem_write = 1'b1;
         end
         OPC_OP_IMM: begin
            alu_op    = decode_alu_op(funct3, alt, 1'b0);
            reg_write = 1'b1;
         end
         OPC_OP: begin
            operand_b = rs2_val;
            alu_op    = decode_alu_op(funct3, alt, 1'b1);
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign shamt = operand_b[4:0];

   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_out = operand_a + operand_b;
         ALU_SUB:  alu_out = operand_a - operand_b;
         ALU_SLL:  alu_out = operand_a << shamt;
         ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
         ALU_XOR:  alu_out = operand_a ^ operand_b;
         ALU_SRL:  alu_out = operand_a >> shamt;
         ALU_SRA:  alu_out = $unsigned($signed(operand_a) >>> shamt);
         ALU_OR:   alu_out = operand_a | operand_b;
         ALU_AND:  alu_out = operand_a & operand_b;
         default:  alu_out = '0;
      endcase
   end

   // Jumps return the link address; JALR clears bit 0 of its target, others do not
   assign alu_result    = link ? pc_plus4 : alu_out;
   assign alu_zero      = (alu_result == '0);
   assign target_base   = (opcode == OPC_JALR) ? rs1_val : pc;
   assign branch_target = (opcode == OPC_JALR) ? ((target_base + imm) & ~XLEN'(1))
                                               : (target_base + imm);

endmodule

// File: tb/tb_rv32i_fetch_decode_execute.sv
// Directed-program bench: each issued instruction queues its hand-computed expected
// outputs; a monitor pops and compares them on the falling edge.
module tb_rv32i_fetch_decode_execute;

   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_OP_IMM = 7'b0010011;
   localparam logic [6:0] T_OP     = 7'b0110011;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b1;
   logic        rst = 1'b1;
   logic [31:0] imem_rdata = NOP;
   logic [31:0] wb_value = '0;
   logic [31:0] imem_addr, pc_out, alu_result, store_data, branch_target;
   logic        alu_zero, mem_read, mem_write, wb_from_load, reg_write, branch_taken;
   logic [2:0]  funct3_out;
   logic [4:0]  rd_out;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu;
      logic        chk_alu;
      logic [4:0]  rd;
      logic        chk_rd;
      logic        rw;
      logic        taken;
      logic [31:0] target;
      logic        chk_tgt;
      logic        mrd;
      logic        mwr;
      logic        wbl;
      logic [31:0] sd;
      logic        chk_sd;
      logic [2:0]  f3;
      logic        chk_f3;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   logic [31:0] model_pc = '0;
   int          assertions = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   rv32i_fetch_decode_execute dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .wb_value      (wb_value),
      .pc_out        (pc_out),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .store_data    (store_data),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .wb_from_load  (wb_from_load),
      .funct3_out    (funct3_out),
      .rd_out        (rd_out),
      .reg_write     (reg_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target)
   );

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm[11:0], rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, T_OP};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic exp_t e_alu(input logic [31:0] alu, input logic [4:0] rd);
      exp_t e = '0;
      e.alu = alu; e.chk_alu = 1'b1; e.rd = rd; e.chk_rd = 1'b1; e.rw = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_br(input logic taken, input logic [31:0] target,
                                 input logic [31:0] alu);
      exp_t e = '0;
      e.taken = taken; e.target = target; e.chk_tgt = 1'b1; e.alu = alu; e.chk_alu = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_jmp(input logic [31:0] alu, input logic [4:0] rd,
                                  input logic [31:0] target);
      exp_t e = e_alu(alu, rd);
      e.taken = 1'b1; e.target = target; e.chk_tgt = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_st(input logic [31:0] alu, input logic [31:0] sd);
      exp_t e = '0;
      e.alu = alu; e.chk_alu = 1'b1; e.mwr = 1'b1; e.sd = sd; e.chk_sd = 1'b1;
      e.f3 = 3'b010; e.chk_f3 = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_ld(input logic [31:0] alu, input logic [4:0] rd);
      exp_t e = e_alu(alu, rd);
      e.mrd = 1'b1; e.wbl = 1'b1; e.f3 = 3'b010; e.chk_f3 = 1'b1;
      return e;
   endfunction

   task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
      end
   endtask

   task automatic applyStimulus(input string name, input logic [31:0] instr,
                                input logic [31:0] wb, input exp_t e_in);
      exp_t e = e_in;
      imem_rdata = instr;
      wb_value   = wb;
      e.pc       = model_pc;
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      if (rst) model_pc = e.taken ? e.target : model_pc + 32'd4;
   endtask

   // Monitor: outputs are combinational, so each issued instruction is judged mid-cycle
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checkOutput({n, ".imem_addr"}, imem_addr, e.pc);
            checkOutput({n, ".pc_out"}, pc_out, e.pc);
            checkOutput({n, ".reg_write"}, 32'(reg_write), 32'(e.rw));
            checkOutput({n, ".branch_taken"}, 32'(branch_taken), 32'(e.taken));
            checkOutput({n, ".mem_read"}, 32'(mem_read), 32'(e.mrd));
            checkOutput({n, ".mem_write"}, 32'(mem_write), 32'(e.mwr));
            checkOutput({n, ".wb_from_load"}, 32'(wb_from_load), 32'(e.wbl));
            if (e.chk_alu) begin
               checkOutput({n, ".alu_result"}, alu_result, e.alu);
               checkOutput({n, ".alu_zero"}, 32'(alu_zero), 32'(e.alu == 32'd0));
            end
            if (e.chk_rd)  checkOutput({n, ".rd_out"}, 32'(rd_out), 32'(e.rd));
            if (e.chk_tgt) checkOutput({n, ".branch_target"}, branch_target, e.target);
            if (e.chk_sd)  checkOutput({n, ".store_data"}, store_data, e.sd);
            if (e.chk_f3)  checkOutput({n, ".funct3_out"}, 32'(funct3_out), 32'(e.f3));
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      applyStimulus("rst_hold", NOP, 32'hDEAD_BEEF, e_alu(32'h0, 5'd0));
      rst = 1'b1;
      applyStimulus("nop_0", NOP, 32'hDEAD_BEEF, e_alu(32'h0, 5'd0));
      applyStimulus("nop_4", NOP, 32'hDEAD_BEEF, e_alu(32'h0, 5'd0));
      applyStimulus("nop_8", NOP, 32'hDEAD_BEEF, e_alu(32'h0, 5'd0));
      rst = 1'b0;
      model_pc = '0;
      applyStimulus("rst_mid", NOP, 32'h0, e_alu(32'h0, 5'd0));
      rst = 1'b1;

      applyStimulus("addi_x1", 32'h0050_0093, 32'd5, e_alu(32'd5, 5'd1));
      applyStimulus("add_x2", 32'h0010_8133, 32'd10, e_alu(32'd10, 5'd2));
      applyStimulus("sub_x3", 32'h4020_81B3, 32'hFFFF_FFFB, e_alu(32'hFFFF_FFFB, 5'd3));
      applyStimulus("addi_x0", enc_i(32'd7, 5'd0, 3'b000, 5'd0, T_OP_IMM), 32'd7, e_alu(32'd7, 5'd0));
      applyStimulus("addi_x1_neg", enc_i(-32'sd8, 5'd0, 3'b000, 5'd1, T_OP_IMM), 32'hFFFF_FFF8,
                    e_alu(32'hFFFF_FFF8, 5'd1));
      applyStimulus("srai", enc_i(32'h401, 5'd1, 3'b101, 5'd4, T_OP_IMM), 32'hFFFF_FFFC,
                    e_alu(32'hFFFF_FFFC, 5'd4));
      applyStimulus("srli", enc_i(32'h001, 5'd1, 3'b101, 5'd4, T_OP_IMM), 32'h7FFF_FFFC,
                    e_alu(32'h7FFF_FFFC, 5'd4));
      applyStimulus("sltu", enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd5), 32'd1, e_alu(32'd1, 5'd5));
      applyStimulus("slt", enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd5), 32'd1, e_alu(32'd1, 5'd5));
      applyStimulus("sra", enc_r(7'h20, 5'd5, 5'd1, 3'b101, 5'd6), 32'hFFFF_FFFC,
                    e_alu(32'hFFFF_FFFC, 5'd6));
      applyStimulus("slli", enc_i(32'd4, 5'd3, 3'b001, 5'd6, T_OP_IMM), 32'hFFFF_FFB0,
                    e_alu(32'hFFFF_FFB0, 5'd6));
      applyStimulus("xori", enc_i(32'h00F, 5'd1, 3'b100, 5'd6, T_OP_IMM), 32'hFFFF_FFF7,
                    e_alu(32'hFFFF_FFF7, 5'd6));

      applyStimulus("beq", enc_b(32'd8, 5'd1, 5'd1, 3'b000), 32'h0, e_br(1'b1, 32'h38, 32'h0));
      applyStimulus("bne", enc_b(32'd8, 5'd1, 5'd1, 3'b001), 32'h0, e_br(1'b0, 32'h40, 32'h0));
      applyStimulus("blt", enc_b(32'd8, 5'd0, 5'd1, 3'b100), 32'h0,
                    e_br(1'b1, 32'h44, 32'hFFFF_FFF8));
      applyStimulus("bltu", enc_b(32'd8, 5'd0, 5'd1, 3'b110), 32'h0,
                    e_br(1'b0, 32'h4C, 32'hFFFF_FFF8));
      applyStimulus("bgeu", enc_b(-32'sd8, 5'd5, 5'd1, 3'b111), 32'h0,
                    e_br(1'b1, 32'h40, 32'hFFFF_FFF7));
      applyStimulus("bge", enc_b(32'd16, 5'd1, 5'd5, 3'b101), 32'h0, e_br(1'b1, 32'h50, 32'd9));
      applyStimulus("br_f3_010", enc_b(32'd8, 5'd1, 5'd1, 3'b010), 32'h0,
                    e_br(1'b0, 32'h58, 32'h0));

      applyStimulus("jal", enc_j(32'd16, 5'd1), 32'h58, e_jmp(32'h58, 5'd1, 32'h64));
      applyStimulus("addi_x5", enc_i(32'h101, 5'd0, 3'b000, 5'd5, T_OP_IMM), 32'h101,
                    e_alu(32'h101, 5'd5));
      applyStimulus("jalr", enc_i(32'd0, 5'd5, 3'b000, 5'd0, T_JALR), 32'h6C,
                    e_jmp(32'h6C, 5'd0, 32'h100));
      applyStimulus("add_x7", enc_r(7'h00, 5'd5, 5'd0, 3'b000, 5'd7), 32'h101,
                    e_alu(32'h101, 5'd7));

      applyStimulus("addi_x2", enc_i(32'h100, 5'd0, 3'b000, 5'd2, T_OP_IMM), 32'h100,
                    e_alu(32'h100, 5'd2));
      applyStimulus("addi_x3", enc_i(32'hAB, 5'd0, 3'b000, 5'd3, T_OP_IMM), 32'hAB,
                    e_alu(32'hAB, 5'd3));
      applyStimulus("sw", enc_s(32'd4, 5'd3, 5'd2), 32'h0, e_st(32'h104, 32'hAB));
      applyStimulus("lw", enc_i(32'd4, 5'd2, 3'b010, 5'd6, T_LOAD), 32'hAB, e_ld(32'h104, 5'd6));
      applyStimulus("sw_x6", enc_s(32'd0, 5'd6, 5'd0), 32'h0, e_st(32'h0, 32'hAB));
      applyStimulus("lui", {20'h12345, 5'd8, T_LUI}, 32'h1234_5000, e_alu(32'h1234_5000, 5'd8));
      applyStimulus("auipc", {20'h00001, 5'd9, T_AUIPC}, 32'h111C, e_alu(32'h111C, 5'd9));
      applyStimulus("fence", 32'h0000_000F, 32'hFFFF_FFFF, exp_t'('0));
      applyStimulus("nop_end", NOP, 32'h0, e_alu(32'h0, 5'd0));

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         assertions++;
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
